// File: rtl/wb_stage_if.sv
// wb_stage_if: bus bundle between the memory stage and the writeback stage.
//
// Signals:
//   mem_to_wb_bus  136  {hi_we, lo_we, hi_wdata, lo_wdata, pc, rf_we, rf_waddr, rf_wdata}
//   wb_to_rf_bus    38  {rf_we, rf_waddr, rf_wdata} to regfile write port / ID bypass
//   hi_o, lo_o      32  bypassed HI/LO values for EX
//   retired_cnt     32  committed-instruction count
//
// Modports:
//   master  upstream side: drives mem_to_wb_bus, observes the writeback outputs
//   slave   wb_stage side: consumes mem_to_wb_bus, drives the writeback outputs
interface wb_stage_if;
    localparam int unsigned MemToWbWd = 136;
    localparam int unsigned WbToRfWd  = 38;

    logic [MemToWbWd-1:0] mem_to_wb_bus;
    logic [WbToRfWd-1:0]  wb_to_rf_bus;
    logic [31:0]          hi_o;
    logic [31:0]          lo_o;
    logic [31:0]          retired_cnt;

    modport master (
        output mem_to_wb_bus,
        input  wb_to_rf_bus,
        input  hi_o,
        input  lo_o,
        input  retired_cnt
    );

    modport slave (
        input  mem_to_wb_bus,
        output wb_to_rf_bus,
        output hi_o,
        output lo_o,
        output retired_cnt
    );
endinterface

// File: rtl/wb_stage.sv
// wb_stage: writeback stage of the 5-stage MIPS core.
//
// Latches the memory-to-writeback bus, drives the regfile write port (with $zero writes
// suppressed), owns the architectural HI/LO pair with same-cycle bypass to EX, and counts
// retired instructions.
//
// Ports:
//   clk      in   core clock, all state on rising edge
//   resetn   in   asynchronous active-low reset
//   stall    in   6-bit stall vector, 1 = stop; bit 4 = WB, bit 5 = downstream of WB
//   bus      slave modport of wb_stage_if (mem_to_wb_bus in; wb_to_rf_bus, hi_o, lo_o,
//            retired_cnt out)
//   debug_wb_pc / _rf_wen / _rf_wnum / _rf_wdata  writeback trace, present only when the
//            macro WB_DEBUG_TRACE_EN is defined
module wb_stage (
    input  logic        clk,
    input  logic        resetn,
    input  logic [5:0]  stall,
    wb_stage_if.slave   bus
`ifdef WB_DEBUG_TRACE_EN
    ,
    output logic [31:0] debug_wb_pc,
    output logic [3:0]  debug_wb_rf_wen,
    output logic [4:0]  debug_wb_rf_wnum,
    output logic [31:0] debug_wb_rf_wdata
`endif
);

    typedef struct packed {
        logic        hi_we;
        logic        lo_we;
        logic [31:0] hi_wdata;
        logic [31:0] lo_wdata;
        logic [31:0] pc;
        logic        rf_we;
        logic [4:0]  rf_waddr;
        logic [31:0] rf_wdata;
    } wb_bus_t;

    wb_bus_t     wb_r_q, wb_r_d;
    logic [31:0] hi_reg_q, hi_reg_d;
    logic [31:0] lo_reg_q, lo_reg_d;
    logic [31:0] retired_cnt_q, retired_cnt_d;

    logic valid;
    logic commit;
    logic rf_we_out;

    // Bubbles are all-zero, so a non-zero PC marks a real instruction.
    assign valid  = (wb_r_q.pc != 32'h0);
    // An entry commits only on the edge where it leaves WB.
    assign commit = valid && !stall[4];

    always_comb begin
        wb_r_d = wb_r_q;
        if (stall[4] && !stall[5]) begin
            wb_r_d = '0;
        end else if (!stall[4]) begin
            wb_r_d = wb_bus_t'(bus.mem_to_wb_bus);
        end
    end

    always_comb begin
        hi_reg_d      = hi_reg_q;
        lo_reg_d      = lo_reg_q;
        retired_cnt_d = retired_cnt_q;
        if (commit) begin
            if (wb_r_q.hi_we) hi_reg_d = wb_r_q.hi_wdata;
            if (wb_r_q.lo_we) lo_reg_d = wb_r_q.lo_wdata;
            retired_cnt_d = retired_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wb_r_q        <= '0;
            hi_reg_q      <= '0;
            lo_reg_q      <= '0;
            retired_cnt_q <= '0;
        end else begin
            wb_r_q        <= wb_r_d;
            hi_reg_q      <= hi_reg_d;
            lo_reg_q      <= lo_reg_d;
            retired_cnt_q <= retired_cnt_d;
        end
    end

    assign rf_we_out        = wb_r_q.rf_we && (wb_r_q.rf_waddr != 5'd0);
    assign bus.wb_to_rf_bus = {rf_we_out, wb_r_q.rf_waddr, wb_r_q.rf_wdata};

    // EX sees the in-flight WB value before it reaches the architectural register.
    assign bus.hi_o = (valid && wb_r_q.hi_we) ? wb_r_q.hi_wdata : hi_reg_q;
    assign bus.lo_o = (valid && wb_r_q.lo_we) ? wb_r_q.lo_wdata : lo_reg_q;

    assign bus.retired_cnt = retired_cnt_q;

`ifdef WB_DEBUG_TRACE_EN
    assign debug_wb_pc       = wb_r_q.pc;
    assign debug_wb_rf_wen   = {4{rf_we_out}};
    assign debug_wb_rf_wnum  = wb_r_q.rf_waddr;
    assign debug_wb_rf_wdata = wb_r_q.rf_wdata;
`endif

endmodule

// File: tb/tb_wb_stage.sv
// tb_wb_stage: directed, table-driven bench for wb_stage plus hand-written sequences for
// asynchronous reset during a stall and retired-counter wrap.
module tb_wb_stage;

    logic       clk;
    logic       resetn;
    logic [5:0] stall;

    wb_stage_if bus_if ();

`ifdef WB_DEBUG_TRACE_EN
    logic [31:0] debug_wb_pc;
    logic [3:0]  debug_wb_rf_wen;
    logic [4:0]  debug_wb_rf_wnum;
    logic [31:0] debug_wb_rf_wdata;
`endif

    wb_stage dut (
        .clk    (clk),
        .resetn (resetn),
        .stall  (stall),
        .bus    (bus_if.slave)
`ifdef WB_DEBUG_TRACE_EN
        ,
        .debug_wb_pc       (debug_wb_pc),
        .debug_wb_rf_wen   (debug_wb_rf_wen),
        .debug_wb_rf_wnum  (debug_wb_rf_wnum),
        .debug_wb_rf_wdata (debug_wb_rf_wdata)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [5:0]   stall;
        logic [135:0] bus;
        logic [37:0]  exp_rf;
        logic [31:0]  exp_hi;
        logic [31:0]  exp_lo;
        logic [31:0]  exp_cnt;
    } vec_t;

    vec_t vecs[$];

    localparam logic [5:0] Run    = 6'b000000;
    localparam logic [5:0] Bubble = 6'b010000;
    localparam logic [5:0] Hold   = 6'b110000;

    function automatic logic [135:0] mk_bus(input logic hi_we, input logic lo_we,
                                            input logic [31:0] hi, input logic [31:0] lo,
                                            input logic [31:0] pc, input logic we,
                                            input logic [4:0] addr, input logic [31:0] data);
        return {hi_we, lo_we, hi, lo, pc, we, addr, data};
    endfunction

    function automatic logic [37:0] rf(input logic we, input logic [4:0] addr,
                                       input logic [31:0] data);
        return {we, addr, data};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_all(input string tag, input logic [37:0] e_rf, input logic [31:0] e_hi,
                             input logic [31:0] e_lo, input logic [31:0] e_cnt);
        check({tag, ".rf"},  {26'h0, bus_if.wb_to_rf_bus}, {26'h0, e_rf});
        check({tag, ".hi"},  {32'h0, bus_if.hi_o},         {32'h0, e_hi});
        check({tag, ".lo"},  {32'h0, bus_if.lo_o},         {32'h0, e_lo});
        check({tag, ".cnt"}, {32'h0, bus_if.retired_cnt},  {32'h0, e_cnt});
    endtask

    task automatic add(input logic [5:0] s, input logic [135:0] b, input logic [37:0] e_rf,
                       input logic [31:0] e_hi, input logic [31:0] e_lo, input logic [31:0] e_cnt);
        vec_t v;
        v.stall = s; v.bus = b; v.exp_rf = e_rf;
        v.exp_hi = e_hi; v.exp_lo = e_lo; v.exp_cnt = e_cnt;
        vecs.push_back(v);
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [159:0] rnd;

        // Expected state after the edge each vector is presented on.
        add(Run, mk_bus(0, 0, 0, 0, 32'hBFC00000, 1, 5'd5, 32'h1234),
            rf(1, 5'd5, 32'h1234), 0, 0, 0);
        add(Run, mk_bus(0, 0, 0, 0, 32'hBFC00004, 1, 5'd0, 32'hFFFFFFFF),
            rf(0, 5'd0, 32'hFFFFFFFF), 0, 0, 1);
        add(Run, mk_bus(1, 1, 32'hAAAA0000, 32'h5555, 32'hBFC00008, 0, 5'd0, 0),
            rf(0, 5'd0, 0), 32'hAAAA0000, 32'h5555, 2);
        add(Run, '0, rf(0, 5'd0, 0), 32'hAAAA0000, 32'h5555, 3);
        add(Run, mk_bus(1, 0, 32'h11112222, 0, 32'hBFC00010, 1, 5'd7, 32'h99),
            rf(1, 5'd7, 32'h99), 32'h11112222, 32'h5555, 3);
        for (int i = 0; i < 3; i++) begin
            add(Hold, mk_bus(0, 0, 0, 0, 32'hBFC00014, 1, 5'd8, 32'h1),
                rf(1, 5'd7, 32'h99), 32'h11112222, 32'h5555, 3);
        end
        add(Run, mk_bus(1, 0, 32'h33334444, 0, 32'hBFC00018, 0, 5'd0, 0),
            rf(0, 5'd0, 0), 32'h33334444, 32'h5555, 4);
        add(Run, mk_bus(1, 0, 32'h55556666, 0, 32'hBFC0001C, 0, 5'd0, 0),
            rf(0, 5'd0, 0), 32'h55556666, 32'h5555, 5);
        // Bubble squashes the young HI write; HI falls back to the register.
        add(Bubble, mk_bus(0, 0, 0, 0, 32'hBFC00020, 1, 5'd9, 32'h5),
            rf(0, 5'd0, 0), 32'h33334444, 32'h5555, 5);
        add(Run, '0, rf(0, 5'd0, 0), 32'h33334444, 32'h5555, 5);
        add(Run, mk_bus(0, 1, 0, 32'hDEADBEEF, 32'hBFC00024, 1, 5'd31, 32'hCAFE),
            rf(1, 5'd31, 32'hCAFE), 32'h33334444, 32'hDEADBEEF, 5);
        add(Run, '0, rf(0, 5'd0, 0), 32'h33334444, 32'hDEADBEEF, 6);

        // Reset with random bus traffic.
        resetn = 1'b0;
        stall  = Run;
        for (int i = 0; i < 3; i++) begin
            rnd = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
            bus_if.mem_to_wb_bus = rnd[135:0];
            @(negedge clk);
        end
        check_all("reset", '0, 0, 0, 0);
        resetn = 1'b1;

        foreach (vecs[i]) begin
            stall = vecs[i].stall;
            bus_if.mem_to_wb_bus = vecs[i].bus;
            @(negedge clk);
            check_all($sformatf("vec%0d", i), vecs[i].exp_rf, vecs[i].exp_hi,
                      vecs[i].exp_lo, vecs[i].exp_cnt);
        end

        // Reset asserted mid-stall with a pending HI/LO write: everything clears at once.
        stall = Run;
        bus_if.mem_to_wb_bus = mk_bus(1, 1, 32'h77778888, 32'h9999, 32'hBFC00100, 1, 5'd4, 32'h44);
        @(negedge clk);
        check_all("pre_rst", rf(1, 5'd4, 32'h44), 32'h77778888, 32'h9999, 6);
        stall = Hold;
        @(negedge clk);
        #2;
        resetn = 1'b0;
        #1;
        check_all("async_rst", '0, 0, 0, 0);
        stall = Run;
        @(negedge clk);
        check_all("rst_held", '0, 0, 0, 0);
        resetn = 1'b1;

        // Counter wrap.
        bus_if.mem_to_wb_bus = mk_bus(0, 0, 0, 0, 32'hBFC00200, 1, 5'd2, 32'h3);
        @(negedge clk);
        check_all("wrap_load", rf(1, 5'd2, 32'h3), 0, 0, 0);
        stall = Hold;
        force dut.retired_cnt_q = 32'hFFFFFFFF;
        #1;
        release dut.retired_cnt_q;
        @(negedge clk);
        check("wrap_held", {32'h0, bus_if.retired_cnt}, 64'hFFFFFFFF);
        stall = Run;
        bus_if.mem_to_wb_bus = '0;
        @(negedge clk);
        check("wrap_zero", {32'h0, bus_if.retired_cnt}, 64'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
